path_accum_queue: RTL and testbench
===================================

PATH_ACCUM_QUEUE -- requirements
Module: path_accum_queue

Interface
REQ-001 Parameter PARAM_NODE_IDX_WIDTH, 10, node index width.
REQ-002 Parameter PARAM_ACCUM_VAL_WIDTH, 24, path-count accumulator width.
REQ-003 Parameter PARAM_FIFO_DEPTH, 32, queue entries; power of two, >=2.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clr  input  1  synchronous clear of queue, end accumulator, overflow.
REQ-007 end_load  input  1  load end node index.
REQ-008 end_idx  input  NODE_IDX_WIDTH  end node index for end_load.
REQ-009 push_valid  input  1  push request.
REQ-010 push_ready  output  1  push can be accepted this cycle.
REQ-011 push_node_idx  input  NODE_IDX_WIDTH  node index of pushed entry.
REQ-012 push_val  input  ACCUM_VAL_WIDTH  path count to add.
REQ-013 pop_valid  output  1  head entry available.
REQ-014 pop_ready  input  1  consumer takes head.
REQ-015 pop_node_idx  output  NODE_IDX_WIDTH  head node index.
REQ-016 pop_val  output  ACCUM_VAL_WIDTH  head accumulated value.
REQ-017 end_accum  output  ACCUM_VAL_WIDTH  accumulated path count into end node.
REQ-018 count  output  clog2(DEPTH)+1  number of valid queue entries.
REQ-019 overflow  output  1  sticky: any saturating add clipped.

Function
REQ-020 Push fires when push_valid & push_ready; pop fires when pop_valid & pop_ready; both may fire same cycle.
REQ-021 end match: end_vld set and push_node_idx == end node register; end push adds push_val to end_accum, never enters queue.
REQ-022 Hit: a valid queue entry holds push_node_idx (CAM compare over all entries); hit push adds push_val to that entry in place, no pointer/count change.
REQ-023 Miss push (no end match, no hit) writes {push_node_idx, push_val, valid=1} at write pointer, write pointer +1 modulo DEPTH.
REQ-024 push_ready = !full | hit | end match; independent of pop_ready (no combinational path pop_ready -> push_ready).
REQ-025 Invariant: at most one valid entry per node index at any time.
REQ-026 pop_valid = count != 0; pop_node_idx/pop_val driven combinationally from head register; pop clears head valid, read pointer +1 modulo DEPTH.
REQ-027 Hit on head entry while pop fires same cycle: pop returns pre-add value; push treated as miss and allocates at tail (count net unchanged).
REQ-028 Full (count == DEPTH) with head-hit and pop firing: tail allocation reuses freed head slot; value not lost.
REQ-029 All adds saturate at 2^ACCUM_VAL_WIDTH-1; clipping sets overflow until clr or reset.
REQ-030 Push/pop effects visible on outputs the cycle after the firing edge (1-cycle latency); count updates same edge.
REQ-031 end_load: end node register <= end_idx, end_vld <= 1, end_accum <= 0; a push firing same cycle compares against the old end register.
REQ-032 clr has priority over end_load, push, pop: all entries invalid, pointers 0, count 0, end_accum 0, overflow 0; end node register and end_vld retained; push_ready still reports per REQ-024 but push is discarded.
REQ-033 Pointer wrap-around transparent; count distinguishes full from empty.

Reset
REQ-034 On rst_n low, immediately: all entries invalid and zeroed, pointers 0, count 0, end_accum 0, end_vld 0, end node register 0, overflow 0; hence pop_valid 0, push_ready 1.
REQ-035 Reset asserted mid-operation abandons in-flight pushes/pops; no partial update survives.

Verification
REQ-036 Push (5,3),(7,2),(5,4), no pop -> count 2; pops return (5,7) then (7,2); pop_valid 0 after.
REQ-037 end_load idx 9; push (9,10),(9,5),(4,1) -> end_accum 15, count 1, head (4,1).
REQ-038 Fill DEPTH distinct nodes -> push_ready 0 for new node, 1 for resident node; hit adds correctly, count stays DEPTH.
REQ-039 Head (3,8) full queue; same cycle pop + push (3,2) -> pop returns (3,8); tail later pops (3,2); count DEPTH.
REQ-040 WIDTH 24: push (1,0xFFFFF0), push (1,0x20) -> value 0xFFFFFF, overflow 1; clr -> count 0, end_accum 0, overflow 0.
REQ-041 Assert rst_n low mid-stream with pushes pending -> outputs at reset values asynchronously; first push after release allocates at slot 0.

Source files
------------

// File: rtl/path_accum_queue_if.sv
// Handshake bundle for the path accumulation queue: push side and pop side.
interface path_accum_queue_if #(
    parameter int NODE_W = 10,
    parameter int VAL_W  = 24
);
    logic              push_valid;
    logic              push_ready;
    logic [NODE_W-1:0] push_node_idx;
    logic [VAL_W-1:0]  push_val;
    logic              pop_valid;
    logic              pop_ready;
    logic [NODE_W-1:0] pop_node_idx;
    logic [VAL_W-1:0]  pop_val;

    modport master (
        output push_valid, push_node_idx, push_val, pop_ready,
        input  push_ready, pop_valid, pop_node_idx, pop_val
    );

    modport slave (
        input  push_valid, push_node_idx, push_val, pop_ready,
        output push_ready, pop_valid, pop_node_idx, pop_val
    );
endinterface

// File: rtl/path_accum_queue.sv
// Path-count accumulation queue: a FIFO of (node, count) entries with a CAM
// lookup so that repeated pushes of a resident node merge in place, plus a
// dedicated saturating accumulator for the designated end node.
module path_accum_queue #(
    parameter int PARAM_NODE_IDX_WIDTH  = 10,
    parameter int PARAM_ACCUM_VAL_WIDTH = 24,
    parameter int PARAM_FIFO_DEPTH      = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clr,
    input  logic                                end_load,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]     end_idx,
    path_accum_queue_if.slave                   q_if,
    output logic [PARAM_ACCUM_VAL_WIDTH-1:0]    end_accum,
    output logic [$clog2(PARAM_FIFO_DEPTH):0]   count,
    output logic                                overflow
);
    localparam int NW    = PARAM_NODE_IDX_WIDTH;
    localparam int VW    = PARAM_ACCUM_VAL_WIDTH;
    localparam int DEPTH = PARAM_FIFO_DEPTH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Saturating add; the top bit of the result flags that clipping happened.
    function automatic logic [VW:0] sat_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[VW]) begin
            sat_add = {1'b1, {VW{1'b1}}};
        end else begin
            sat_add = sum;
        end
    endfunction

    logic [NW-1:0]    node_q [DEPTH];
    logic [NW-1:0]    node_d [DEPTH];
    logic [VW-1:0]    val_q  [DEPTH];
    logic [VW-1:0]    val_d  [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [NW-1:0]    end_idx_q, end_idx_d;
    logic             end_vld_q, end_vld_d;
    logic [VW-1:0]    end_accum_q, end_accum_d;
    logic             overflow_q, overflow_d;

    logic             hit_any_s;
    logic [PTR_W-1:0] hit_idx_s;
    logic             end_match_s, full_s, push_fire_s, pop_fire_s, head_hit_pop_s;
    logic             alloc_s;
    logic [VW:0]      sat_s;

    assign end_match_s    = end_vld_q && (q_if.push_node_idx == end_idx_q);
    assign full_s         = (count_q == CNT_W'(DEPTH));
    assign q_if.push_ready = !full_s || hit_any_s || end_match_s;
    assign q_if.pop_valid  = (count_q != {CNT_W{1'b0}});
    assign q_if.pop_node_idx = node_q[rd_ptr_q];
    assign q_if.pop_val      = val_q[rd_ptr_q];
    assign push_fire_s    = q_if.push_valid && q_if.push_ready;
    assign pop_fire_s     = q_if.pop_valid && q_if.pop_ready;
    assign head_hit_pop_s = hit_any_s && (hit_idx_s == rd_ptr_q) && pop_fire_s;
    assign end_accum      = end_accum_q;
    assign count          = count_q;
    assign overflow       = overflow_q;

    // CAM lookup of the pushed node index across all valid entries.
    always_comb begin
        hit_any_s = 1'b0;
        hit_idx_s = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (node_q[i] == q_if.push_node_idx)) begin
                hit_any_s = 1'b1;
                hit_idx_s = PTR_W'(i);
            end else begin
                hit_any_s = hit_any_s;
            end
        end
    end

    // Next-state: clear, pop, push (end / merge / allocate), then end-node load.
    always_comb begin
        node_d      = node_q;
        val_d       = val_q;
        vld_d       = vld_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        end_idx_d   = end_idx_q;
        end_vld_d   = end_vld_q;
        end_accum_d = end_accum_q;
        overflow_d  = overflow_q;
        alloc_s     = 1'b0;
        sat_s       = {(VW+1){1'b0}};
        if (clr) begin
            vld_d       = {DEPTH{1'b0}};
            wr_ptr_d    = {PTR_W{1'b0}};
            rd_ptr_d    = {PTR_W{1'b0}};
            count_d     = {CNT_W{1'b0}};
            end_accum_d = {VW{1'b0}};
            overflow_d  = 1'b0;
        end else begin
            // Pop first so a full-queue head-hit allocation can reuse the freed slot.
            if (pop_fire_s) begin
                vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_fire_s) begin
                if (end_match_s) begin
                    sat_s       = sat_add(end_accum_q, q_if.push_val);
                    end_accum_d = sat_s[VW-1:0];
                    overflow_d  = overflow_q | sat_s[VW];
                end else if (hit_any_s && !head_hit_pop_s) begin
                    sat_s            = sat_add(val_q[hit_idx_s], q_if.push_val);
                    val_d[hit_idx_s] = sat_s[VW-1:0];
                    overflow_d       = overflow_q | sat_s[VW];
                end else begin
                    alloc_s          = 1'b1;
                    node_d[wr_ptr_q] = q_if.push_node_idx;
                    val_d[wr_ptr_q]  = q_if.push_val;
                    vld_d[wr_ptr_q]  = 1'b1;
                    wr_ptr_d         = wr_ptr_q + PTR_W'(1);
                end
            end else begin
                alloc_s = 1'b0;
            end
            count_d = count_q + CNT_W'(alloc_s) - CNT_W'(pop_fire_s);
            // A same-cycle push has already been matched against the old end node.
            if (end_load) begin
                end_idx_d   = end_idx;
                end_vld_d   = 1'b1;
                end_accum_d = {VW{1'b0}};
            end else begin
                end_vld_d = end_vld_q;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                node_q[i] <= {NW{1'b0}};
                val_q[i]  <= {VW{1'b0}};
            end
            vld_q       <= {DEPTH{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            end_idx_q   <= {NW{1'b0}};
            end_vld_q   <= 1'b0;
            end_accum_q <= {VW{1'b0}};
            overflow_q  <= 1'b0;
        end else begin
            node_q      <= node_d;
            val_q       <= val_d;
            vld_q       <= vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            end_idx_q   <= end_idx_d;
            end_vld_q   <= end_vld_d;
            end_accum_q <= end_accum_d;
            overflow_q  <= overflow_d;
        end
    end
endmodule

// File: tb/tb_path_accum_queue.sv
// Self-checking bench for path_accum_queue: queue-based reference model,
// per-cycle compare on the falling edge, and directed literal checks.
module tb_path_accum_queue;
    localparam int NW    = 10;
    localparam int VW    = 24;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          end_load = 1'b0;
    logic [NW-1:0] end_idx = '0;
    logic [VW-1:0] end_accum;
    logic [5:0]    count;
    logic          overflow;

    int n_cmp = 0;
    int n_err = 0;

    path_accum_queue_if #(.NODE_W(NW), .VAL_W(VW)) q_if ();

    path_accum_queue #(
        .PARAM_NODE_IDX_WIDTH(NW),
        .PARAM_ACCUM_VAL_WIDTH(VW),
        .PARAM_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .end_load(end_load), .end_idx(end_idx),
        .q_if(q_if), .end_accum(end_accum), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [NW-1:0] n;
        logic [VW-1:0] v;
    } ent_t;

    ent_t          mq[$];
    logic [NW-1:0] m_end_idx = '0;
    logic          m_end_vld = 1'b0;
    logic [VW-1:0] m_end_acc = '0;
    logic          m_ovf = 1'b0;

    function automatic int mfind(input logic [NW-1:0] n);
        for (int i = 0; i < mq.size(); i++) if (mq[i].n == n) return i;
        return -1;
    endfunction

    function automatic logic m_ready(input logic [NW-1:0] n);
        return (mq.size() < DEPTH) || (mfind(n) >= 0) || (m_end_vld && n == m_end_idx);
    endfunction

    function automatic logic [VW-1:0] msat(input logic [VW-1:0] a, input logic [VW-1:0] b);
        longint s;
        s = longint'(a) + longint'(b);
        if (s > longint'(24'hFFFFFF)) begin
            m_ovf = 1'b1;
            return 24'hFFFFFF;
        end
        return s[VW-1:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_end_idx = '0; m_end_vld = 1'b0; m_end_acc = '0; m_ovf = 1'b0;
        end else if (clr) begin
            mq.delete();
            m_end_acc = '0; m_ovf = 1'b0;
        end else begin
            logic pf, popf, alloc, em;
            int   k;
            ent_t e;
            pf    = q_if.push_valid && m_ready(q_if.push_node_idx);
            popf  = (mq.size() > 0) && q_if.pop_ready;
            em    = m_end_vld && (q_if.push_node_idx == m_end_idx);
            k     = mfind(q_if.push_node_idx);
            alloc = 1'b0;
            if (pf) begin
                if (em) m_end_acc = msat(m_end_acc, q_if.push_val);
                else if (k >= 0 && !(k == 0 && popf)) mq[k].v = msat(mq[k].v, q_if.push_val);
                else alloc = 1'b1;
            end
            if (popf) void'(mq.pop_front());
            if (alloc) begin
                e.n = q_if.push_node_idx; e.v = q_if.push_val;
                mq.push_back(e);
            end
            if (end_load) begin
                m_end_idx = end_idx; m_end_vld = 1'b1; m_end_acc = '0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_pop_valid", 32'(q_if.pop_valid), 32'(mq.size() != 0));
            chk("m_push_ready", 32'(q_if.push_ready), 32'(m_ready(q_if.push_node_idx)));
            chk("m_end_accum", 32'(end_accum), 32'(m_end_acc));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            if (mq.size() != 0) begin
                chk("m_head_node", 32'(q_if.pop_node_idx), 32'(mq[0].n));
                chk("m_head_val", 32'(q_if.pop_val), 32'(mq[0].v));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int n, input int v);
        q_if.push_valid = 1'b1;
        q_if.push_node_idx = NW'(n);
        q_if.push_val = VW'(v);
        tick();
        q_if.push_valid = 1'b0;
    endtask

    task automatic pop();
        q_if.pop_ready = 1'b1;
        tick();
        q_if.pop_ready = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic head(input string nm, input int n, input int v);
        chk({nm, "_valid"}, 32'(q_if.pop_valid), 32'd1);
        chk({nm, "_node"}, 32'(q_if.pop_node_idx), 32'(n));
        chk({nm, "_val"}, 32'(q_if.pop_val), 32'(v));
    endtask

    task automatic reset_state(input string nm);
        chk({nm, "_count"}, 32'(count), 32'd0);
        chk({nm, "_pop_valid"}, 32'(q_if.pop_valid), 32'd0);
        chk({nm, "_push_ready"}, 32'(q_if.push_ready), 32'd1);
        chk({nm, "_end_accum"}, 32'(end_accum), 32'd0);
        chk({nm, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        q_if.push_valid = 1'b0;
        q_if.push_node_idx = '0;
        q_if.push_val = '0;
        q_if.pop_ready = 1'b0;
        #3;
        reset_state("rst");
        #10 rst_n = 1'b1;
        tick();

        // Merge of a repeated node, then drain in order.
        push(5, 3); push(7, 2); push(5, 4);
        chk("merge_count", 32'(count), 32'd2);
        head("merge_h0", 5, 7);
        pop();
        head("merge_h1", 7, 2);
        pop();
        chk("merge_empty", 32'(q_if.pop_valid), 32'd0);

        // End node accumulation bypasses the queue.
        end_load = 1'b1; end_idx = NW'(9);
        tick();
        end_load = 1'b0;
        push(9, 10); push(9, 5); push(4, 1);
        chk("end_accum", 32'(end_accum), 32'd15);
        chk("end_count", 32'(count), 32'd1);
        head("end_head", 4, 1);
        pop();

        // Full queue: new node stalls, resident node merges.
        do_clr();
        for (int i = 0; i < DEPTH; i++) push(100 + i, i + 1);
        chk("full_count", 32'(count), 32'd32);
        q_if.push_node_idx = NW'(200);
        #1 chk("full_ready_new", 32'(q_if.push_ready), 32'd0);
        q_if.push_node_idx = NW'(110);
        #1 chk("full_ready_hit", 32'(q_if.push_ready), 32'd1);
        push(110, 5);
        chk("full_hit_count", 32'(count), 32'd32);
        head("full_head", 100, 1);
        for (int i = 0; i < 10; i++) pop();
        head("full_merged", 110, 16);

        // Full queue, head hit with simultaneous pop.
        do_clr();
        push(3, 8);
        for (int i = 1; i < DEPTH; i++) push(20 + i, i);
        chk("hh_count_pre", 32'(count), 32'd32);
        q_if.push_valid = 1'b1; q_if.push_node_idx = NW'(3); q_if.push_val = VW'(2);
        q_if.pop_ready = 1'b1;
        #1;
        head("hh_pop", 3, 8);
        chk("hh_ready", 32'(q_if.push_ready), 32'd1);
        tick();
        q_if.push_valid = 1'b0; q_if.pop_ready = 1'b0;
        chk("hh_count_post", 32'(count), 32'd32);
        head("hh_next", 21, 1);
        for (int i = 1; i < DEPTH; i++) pop();
        head("hh_tail", 3, 2);
        chk("hh_count_end", 32'(count), 32'd1);

        // Saturation, sticky overflow, and clear.
        do_clr();
        push(1, 24'hFFFFF0); push(1, 24'h20);
        head("sat", 1, 24'hFFFFFF);
        chk("sat_ovf", 32'(overflow), 32'd1);
        push(9, 7);
        chk("sat_end", 32'(end_accum), 32'd7);
        clr = 1'b1;
        q_if.push_valid = 1'b1; q_if.push_node_idx = NW'(2); q_if.push_val = VW'(1);
        tick();
        clr = 1'b0; q_if.push_valid = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_end", 32'(end_accum), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        push(9, 1);
        chk("clr_end_kept", 32'(end_accum), 32'd1);

        // Asynchronous reset mid-stream.
        push(11, 1); push(12, 2);
        q_if.push_valid = 1'b1; q_if.push_node_idx = NW'(13); q_if.push_val = VW'(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 reset_state("async");
        q_if.push_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        push(6, 6);
        chk("post_rst_count", 32'(count), 32'd1);
        head("post_rst", 6, 6);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
